// File: rtl/alu_exec_unit.sv
// Registered, handshaked execute stage: single-cycle logic/arithmetic ops and
// bit-serial shifts, with result/zero/illegal held under a valid/ready handshake.
module alu_exec_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] acc_q, acc_step;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_shift;
  logic             slt;
  logic [SHW-1:0]   amt;

  assign amt = b[SHW-1:0];
  assign slt = $signed(a) < $signed(b);

  // Shift ops report a here so a shift by zero completes like a 1-cycle op.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = a;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    acc_step = acc_q;
    case (op_q)
      OP_SLL:  acc_step = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (is_shift && amt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_AND;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op_t'(alu_ctrl);
            illegal_q <= alu_ill;
            if (is_shift && amt != '0) begin
              acc_q <= a;
              cnt_q <= amt;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q <= acc_step;
            zero_q   <= (acc_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops
// checked against a behavioural model of results and latencies.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: result, illegal flag and accept-to-valid latency in cycles.
  function automatic void model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(y[4:0]);
    ill = 1'b0;
    lat = 1;
    r   = '0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin r = x << sh; lat = 1 + sh; end
      4'b1001: begin r = x >> sh; lat = 1 + sh; end
      4'b1010: begin r = $signed(x) >>> sh; lat = 1 + sh; end
      default: begin r = '0; ill = 1'b1; end
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          n;
    model(c, x, y, er, ei, el);
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    // Scramble inputs and keep in_valid asserted: must be ignored while busy.
    alu_ctrl = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    check("busy_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("latency", n, el);
    check("result", result, er);
    check("zero", {31'd0, zero}, {31'd0, (er == 32'd0)});
    check("illegal", {31'd0, illegal}, {31'd0, ei});
    got = result;
    repeat (hold) begin
      @(negedge clk);
      check("hold_result", result, er);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [3:0]  codes [12];
    int          stale;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
              4'b1001, 4'b1010, 4'b0011, 4'b0101, 4'b1111, 4'b1011};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = '0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'b0110, 32'h5, 32'h5, 0, got);
    check("sub_zero", got, 32'h0);
    run_op(4'b0010, 32'h5, 32'h5, 0, got);
    check("add", got, 32'hA);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0, got);
    check("slt_neg", got, 32'h1);
    run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, 0, got);
    check("slt_pos", got, 32'h0);
    run_op(4'b1010, 32'h8000_0000, 32'h24, 0, got);
    check("sra4", got, 32'hF800_0000);
    run_op(4'b1001, 32'h8000_0000, 32'h24, 0, got);
    check("srl4", got, 32'h0800_0000);
    run_op(4'b1000, 32'h1, 32'd31, 0, got);
    check("sll31", got, 32'h8000_0000);
    run_op(4'b1000, 32'h1234_5678, 32'h20, 0, got);
    check("sll0", got, 32'h1234_5678);
    run_op(4'b0101, 32'hDEAD_BEEF, 32'h1, 0, got);
    check("illegal_res", got, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  c;
      logic [31:0] x;
      logic [31:0] y;
      c = codes[$urandom_range(11, 0)];
      x = $urandom;
      y = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(31, 0)) : $urandom;
      if ($urandom_range(7, 0) == 0) y = x;
      run_op(c, x, y, $urandom_range(3, 0), got);
    end

    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 10, got);
    check("and_bp", got, 32'hF000_F000);

    // Reset five cycles into a 20-step shift.
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b1001;
    a        = 32'hDEAD_BEEF;
    b        = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_valid", stale, 0);
    check("no_stale_result", result, 32'd0);
    run_op(4'b0010, 32'd2, 32'd3, 0, got);
    check("add_after_rst", got, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered, handshaked execute stage consuming the 4-bit ALU control code produced by the ALU control decoder plus the two operands from the register file/immediate mux. It performs logic and arithmetic ops in one cycle and shifts iteratively, one bit per cycle, to keep the datapath small. It presents the result and a zero flag to branch and writeback logic under a valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, at least 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an op; high only in IDLE
- alu_ctrl  input  4  operation code
- a  input  WIDTH  operand A, rs1
- b  input  WIDTH  operand B, rs2 or imm
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- illegal  output  1  op code unsupported; qualified by out_valid

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a − b, mod 2^WIDTH)
  - 0111 SLT (signed a < b ? 1 : 0)
  - 1000 SLL
  - 1001 SRL
  - 1010 SRA
- Any other code, including X-free undefined codes: result = 0, zero = 1, illegal = 1. Completes like a 1-cycle op.
- Shift amount is b[SHW-1:0]; upper bits of b are ignored.
- Arithmetic wraps; no carry or overflow outputs.
- States:
  - IDLE (reset state)
  - SHIFT
  - DONE
- IDLE:
  - in_ready = 1.
  - On in_valid, capture alu_ctrl, a and b.
  - Non-shift op: compute into the result register, go to DONE.
  - Shift op with amount 0: result = a, go to DONE.
  - Shift op with amount > 0: acc = a, cnt = amount, go to SHIFT.
- SHIFT:
  - Each cycle, acc shifts by 1: SLL fills 0, SRL fills 0, SRA fills acc MSB. cnt decrements.
  - When cnt transitions 1→0, load result from the shifted acc and go to DONE.
  - in_ready = 0.
- DONE:
  - out_valid = 1; result, zero and illegal are held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready = 0.
- No overlap: a new op is never accepted in the same cycle as the output handshake.
- Operand or control changes after acceptance have no effect.
- in_ready, out_valid and illegal are decodes of registered state. There are no combinational paths from in_* to out_*.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, in_ready = 1
  - out_valid = 0, result = 0, zero = 0, illegal = 0
  - acc and cnt = 0
- Latency from accept edge to out_valid high:
  - 1 cycle for non-shift ops, illegal codes, and shifts by 0.
  - 1 + N cycles for a shift by N (N ≤ WIDTH−1).
- Max throughput: one op per 2 cycles (accept, then DONE handshake). Back-pressure holds DONE indefinitely.
- zero is registered with result and valid whenever out_valid = 1.
- Reset asserted mid-SHIFT or in DONE abandons the op. Outputs return to reset values immediately; no stale result appears after release.
- in_valid while not in IDLE is ignored; the requester must hold it until in_ready.

## Test plan
- ADD/SUB/zero:
  - a = 0x0000_0005, b = 0x0000_0005, code 0110 → 1 cycle later out_valid, result 0, zero 1.
  - Same operands, code 0010 → result 0x0000_000A, zero 0.
- SLT signed:
  - a = 0xFFFF_FFFF (−1), b = 1, code 0111 → result 1.
  - a = 1, b = 0xFFFF_FFFF → result 0.
- Iterative shifts:
  - SRA a = 0x8000_0000, b = 0x0000_0024 (amount 4) → out_valid exactly 5 cycles after accept, result 0xF800_0000.
  - SRL, same operands → 0x0800_0000.
  - SLL a = 1, b = 31 → 0x8000_0000 after 32 cycles.
- Shift by 0 and illegal code:
  - SLL a = 0x1234_5678, b = 0x20 → 1-cycle latency, result 0x1234_5678.
  - Code 0101 → result 0, zero 1, illegal 1.
- Back-pressure:
  - Hold out_ready = 0 for 10 cycles after AND of 0xF0F0_F0F0 and 0xFF00_FF00 → result 0xF000_F000 stable, out_valid high, in_ready low.
  - Pulse out_ready → IDLE next cycle, in_ready high.
- Reset mid-op:
  - Assert rst_n = 0 during SHIFT (amount 20, 5 cycles in) → out_valid and result 0 immediately, with no out_valid pulse after release.
  - Next ADD 2 + 3 → result 5.
